// File: rtl/msrv32_ahb_dmem_bridge.sv
// msrv32_ahb_dmem_bridge: data-side AHB-Lite master bridge for the msrv32 core data-memory port.
// Converts single-cycle core load/store requests into AHB-Lite transfers (address phase, then data phase).
// It absorbs wait states and the two-cycle ERROR response, then returns one response pulse per request.
// Core side:
//   req_valid_in/req_wr_in/req_addr_in/req_size_in/req_wdata_in carry the request.
//   req_ready_out is the accept handshake, and stall_out holds the pipeline.
//   rsp_valid_out/rsp_rdata_out/rsp_err_out return the response.
// Bus side:
//   haddr_out/htrans_out/hwrite_out/hsize_out/hwdata_out are the master outputs.
//   hrdata_in/hready_in/hresp_in are the slave response.
// Optional: define MSRV32_BUS_ERR_CAPTURE_EN to latch the faulting address on err_addr_out.
module msrv32_ahb_dmem_bridge #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] ERR_ADDR_RST = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid_in,
    input  logic              req_wr_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [1:0]        req_size_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    output logic              req_ready_out,
    output logic              stall_out,
    output logic              rsp_valid_out,
    output logic [DATA_W-1:0] rsp_rdata_out,
    output logic              rsp_err_out,
    output logic [ADDR_W-1:0] haddr_out,
    output logic [1:0]        htrans_out,
    output logic              hwrite_out,
    output logic [2:0]        hsize_out,
    output logic [DATA_W-1:0] hwdata_out,
    input  logic [DATA_W-1:0] hrdata_in,
    input  logic              hready_in,
    input  logic              hresp_in,
    output logic [ADDR_W-1:0] err_addr_out
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid, r_rsp_err;
    logic [DATA_W-1:0] r_rdata;
    logic              w_illegal, w_done, w_err;
    logic [DATA_W-1:0] w_rdata;

    assign w_illegal = (req_size_in == 2'b11) || (req_size_in == 2'b01 && req_addr_in[0]) ||
                       (req_size_in == 2'b10 && req_addr_in[1:0] != 2'b00);

    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_rdata = '0;
        case (r_state)
            IDLE: if (req_valid_in) begin
                if (w_illegal) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end else w_next = ADDR;
            end
            ADDR: if (hready_in) w_next = DATA;
            // hready+hresp without a prior ERR cycle is a slave protocol violation; end it as an error
            DATA: if (hready_in) begin
                w_next  = IDLE;
                w_done  = 1'b1;
                w_err   = hresp_in;
                w_rdata = (hresp_in || r_wr) ? '0 : hrdata_in;
            end else if (hresp_in) w_next = ERR;
            ERR: if (hready_in) begin
                w_next = IDLE;
                w_done = 1'b1;
                w_err  = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_size      <= 2'b10;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= w_done;
            r_rsp_err   <= w_err;
            if (w_done) r_rdata <= w_rdata;
            if (r_state == IDLE && req_valid_in && !w_illegal) begin
                r_addr  <= req_addr_in;
                r_size  <= req_size_in;
                r_wr    <= req_wr_in;
                r_wdata <= req_wdata_in;
            end
        end
    end

    assign req_ready_out = r_state == IDLE;
    assign stall_out     = r_state != IDLE;
    assign rsp_valid_out = r_rsp_valid;
    assign rsp_err_out   = r_rsp_err;
    assign rsp_rdata_out = r_rdata;
    assign htrans_out    = (r_state == ADDR) ? 2'b10 : 2'b00;
    assign haddr_out     = r_addr;
    assign hwrite_out    = r_wr;
    assign hsize_out     = {1'b0, r_size};
    assign hwdata_out    = r_wdata;

`ifdef MSRV32_BUS_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] r_err_addr;

    // illegal requests fault in IDLE on the live address; bus errors on the registered one
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_err_addr <= ERR_ADDR_RST;
        else if (w_done && w_err) r_err_addr <= (r_state == IDLE) ? req_addr_in : r_addr;
    end

    assign err_addr_out = r_err_addr;
`else
    assign err_addr_out = ERR_ADDR_RST & '0;
`endif
endmodule
